// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through L1 req/rtrn protocol: a flop line memory
// behind an in-order, fixed-latency response FIFO of up to MaxTx in-flight transactions.
module wt_mem_responder #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128,
    parameter int TidWidth  = 2,
    parameter int NumLines  = 16,
    parameter int Latency   = 3,
    parameter int MaxTx     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 req_ack_o,
    input  logic [1:0]           req_type_i,
    input  logic [AddrWidth-1:0] req_paddr_i,
    input  logic [2:0]           req_size_i,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [TidWidth-1:0]  req_tid_i,
    output logic                 rtrn_vld_o,
    output logic [1:0]           rtrn_type_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic [LineWidth-1:0] rtrn_data_o,
    output logic                 err_o
);

    localparam int LineBytes = LineWidth / 8;
    localparam int DataBytes = DataWidth / 8;
    localparam int OffW      = $clog2(LineBytes);
    localparam int IdxW      = $clog2(NumLines);
    localparam int DOffW     = $clog2(DataBytes);
    localparam int CntW      = $clog2(Latency + 1);
    localparam int PtrW      = (MaxTx > 1) ? $clog2(MaxTx) : 1;
    localparam int OccW      = $clog2(MaxTx + 1);

    localparam logic [1:0] TypeLoad  = 2'd0;
    localparam logic [1:0] TypeIfill = 2'd1;
    localparam logic [1:0] TypeStore = 2'd2;

    logic [LineWidth-1:0] mem_q [NumLines];

    logic [1:0]           fifo_type_q [MaxTx];
    logic [TidWidth-1:0]  fifo_tid_q  [MaxTx];
    logic [LineWidth-1:0] fifo_data_q [MaxTx];
    logic [CntW-1:0]      fifo_cnt_q  [MaxTx];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;

    logic                 rtrn_vld_q, rtrn_vld_d;
    logic [1:0]           rtrn_type_q, rtrn_type_d;
    logic [TidWidth-1:0]  rtrn_tid_q, rtrn_tid_d;
    logic [LineWidth-1:0] rtrn_data_q, rtrn_data_d;
    logic                 err_q, err_d;

    logic                 accept_s, push_s, pop_s;
    logic                 is_store_s, store_ok_s, bad_req_s, mem_we_s;
    logic [IdxW-1:0]      idx_s;
    logic [OffW-1:0]      off_s;
    logic [LineWidth-1:0] rd_line_s, store_line_s, resp_data_s;
    int                   off_int_s, doff_int_s, nbytes_s;
    logic                 unused_s;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTx - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    assign unused_s = ^req_paddr_i[AddrWidth-1:OffW+IdxW];

    assign idx_s     = req_paddr_i[OffW +: IdxW];
    assign off_s     = req_paddr_i[OffW-1:0];
    assign rd_line_s = mem_q[idx_s];

    // Outstanding minus retiring equals the FIFO occupancy, so the ack only looks at occ_q.
    assign accept_s  = req_i & ~rst_i & (occ_q < OccW'(MaxTx));
    assign push_s    = accept_s & (Latency > 1);
    assign pop_s     = (occ_q != {OccW{1'b0}}) & (fifo_cnt_q[rd_ptr_q] == CntW'(1));
    assign req_ack_o = accept_s;

    // Store legality and the merged line (lane-positioned data shifted into line offset)
    always_comb begin
        off_int_s    = int'(off_s);
        doff_int_s   = off_int_s & (DataBytes - 1);
        nbytes_s     = 32'sd1 << req_size_i;
        is_store_s   = (req_type_i == TypeStore);
        store_ok_s   = (int'(req_size_i) <= DOffW) && ((off_int_s & (nbytes_s - 32'sd1)) == 32'sd0);
        store_line_s = rd_line_s;
        for (int j = 0; j < LineBytes; j++) begin
            if ((j >= off_int_s) && (j < off_int_s + nbytes_s)) begin
                store_line_s[8*j +: 8] = req_data_i[8*((doff_int_s + j - off_int_s) & (DataBytes - 1)) +: 8];
            end else begin
                store_line_s[8*j +: 8] = rd_line_s[8*j +: 8];
            end
        end
        mem_we_s  = accept_s & is_store_s & store_ok_s;
        bad_req_s = accept_s & ((req_type_i == 2'd3) | (is_store_s & ~store_ok_s));
        case (req_type_i)
            TypeLoad, TypeIfill: resp_data_s = rd_line_s;
            default:             resp_data_s = {LineWidth{1'b0}};
        endcase
    end

    // FIFO pointer/occupancy bookkeeping and the next registered response
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q + OccW'(push_s) - OccW'(pop_s);
        rtrn_vld_d  = 1'b0;
        rtrn_type_d = 2'd0;
        rtrn_tid_d  = {TidWidth{1'b0}};
        rtrn_data_d = {LineWidth{1'b0}};
        err_d       = err_q | bad_req_s;
        if (push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if ((Latency == 1) && accept_s) begin
            rtrn_vld_d  = 1'b1;
            rtrn_type_d = req_type_i;
            rtrn_tid_d  = req_tid_i;
            rtrn_data_d = resp_data_s;
        end else if ((Latency > 1) && pop_s) begin
            rtrn_vld_d  = 1'b1;
            rtrn_type_d = fifo_type_q[rd_ptr_q];
            rtrn_tid_d  = fifo_tid_q[rd_ptr_q];
            rtrn_data_d = fifo_data_q[rd_ptr_q];
        end else begin
            rtrn_vld_d  = 1'b0;
        end
    end

    // State registers: line memory, in-flight entries with countdowns, outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumLines; i++) begin
                mem_q[i] <= {LineWidth{1'b0}};
            end
            for (int i = 0; i < MaxTx; i++) begin
                fifo_cnt_q[i] <= {CntW{1'b0}};
            end
            rd_ptr_q    <= {PtrW{1'b0}};
            wr_ptr_q    <= {PtrW{1'b0}};
            occ_q       <= {OccW{1'b0}};
            rtrn_vld_q  <= 1'b0;
            rtrn_type_q <= 2'd0;
            rtrn_tid_q  <= {TidWidth{1'b0}};
            rtrn_data_q <= {LineWidth{1'b0}};
            err_q       <= 1'b0;
        end else begin
            if (mem_we_s) begin
                mem_q[idx_s] <= store_line_s;
            end
            for (int i = 0; i < MaxTx; i++) begin
                if (fifo_cnt_q[i] > CntW'(1)) begin
                    fifo_cnt_q[i] <= fifo_cnt_q[i] - CntW'(1);
                end
            end
            // The load data is captured here, so later stores never reach an accepted load.
            if (push_s) begin
                fifo_type_q[wr_ptr_q] <= req_type_i;
                fifo_tid_q[wr_ptr_q]  <= req_tid_i;
                fifo_data_q[wr_ptr_q] <= resp_data_s;
                fifo_cnt_q[wr_ptr_q]  <= CntW'(Latency - 1);
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            rtrn_vld_q  <= rtrn_vld_d;
            rtrn_type_q <= rtrn_type_d;
            rtrn_tid_q  <= rtrn_tid_d;
            rtrn_data_q <= rtrn_data_d;
            err_q       <= err_d;
        end
    end

    assign rtrn_vld_o  = rtrn_vld_q;
    assign rtrn_type_o = rtrn_type_q;
    assign rtrn_tid_o  = rtrn_tid_q;
    assign rtrn_data_o = rtrn_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_wt_mem_responder.sv
// Scoreboard bench for wt_mem_responder: directed requests push expected responses,
// a negedge monitor pops and compares type, tid, data and response cycle.
module tb_wt_mem_responder;

    localparam int LAT = 3;
    localparam logic [1:0] LD = 2'd0, IF = 2'd1, ST = 2'd2, RS = 2'd3;

    logic         clk = 1'b0;
    logic         rst_i, req_i, req_ack_o;
    logic [1:0]   req_type_i;
    logic [31:0]  req_paddr_i;
    logic [2:0]   req_size_i;
    logic [63:0]  req_data_i;
    logic [1:0]   req_tid_i;
    logic         rtrn_vld_o;
    logic [1:0]   rtrn_type_o;
    logic [1:0]   rtrn_tid_o;
    logic [127:0] rtrn_data_o;
    logic         err_o;

    always #5 clk = ~clk;

    wt_mem_responder dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_ack_o(req_ack_o),
        .req_type_i(req_type_i), .req_paddr_i(req_paddr_i), .req_size_i(req_size_i),
        .req_data_i(req_data_i), .req_tid_i(req_tid_i), .rtrn_vld_o(rtrn_vld_o),
        .rtrn_type_o(rtrn_type_o), .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o),
        .err_o(err_o)
    );

    typedef struct {
        logic [1:0]   t;
        logic [1:0]   tid;
        logic [127:0] d;
        int           c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [127:0] L1 = {64'h1122334455667788, 64'h0};
    localparam logic [127:0] L2 = {64'h1122334455667788, 64'h00000000AB000000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rtrn_vld_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rtrn", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rtrn_type", 128'(rtrn_type_o), 128'(e.t));
                chk("rtrn_tid", 128'(rtrn_tid_o), 128'(e.tid));
                chk("rtrn_data", rtrn_data_o, e.d);
                chk("rtrn_cycle", 128'(cyc), 128'(e.c));
            end
        end
    end

    task automatic push_exp(input logic [1:0] t, input logic [1:0] tid, input logic [127:0] d);
        exp_t e;
        e.t = t; e.tid = tid; e.d = d; e.c = cyc + LAT;
        sb.push_back(e);
    endtask

    // Holds req_i until acked (bounded), leaves req_i high one tick past the accept edge.
    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] d, input logic [1:0] tid, input logic [127:0] exp_d,
                        output int ack_c);
        bit got;
        got = 1'b0;
        ack_c = -1;
        req_i = 1'b1; req_type_i = t; req_paddr_i = a; req_size_i = sz;
        req_data_i = d; req_tid_i = tid;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ack_o === 1'b1) begin
                got = 1'b1;
                ack_c = cyc;
                push_exp(t, tid, exp_d);
            end
        end
        if (!got) chk("ack_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int ac, s, a[4];
        int exp_gap[4];
        exp_gap[0] = 0; exp_gap[1] = 1; exp_gap[2] = 3; exp_gap[3] = 4;

        rst_i = 1'b1; req_i = 1'b1; req_type_i = LD; req_paddr_i = 32'h40;
        req_size_i = 3'd0; req_data_i = 64'h0; req_tid_i = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ack_in_reset", 128'(req_ack_o), 128'd0);
        chk("rst_vld", 128'(rtrn_vld_o), 128'd0);
        chk("rst_type", 128'(rtrn_type_o), 128'd0);
        chk("rst_tid", 128'(rtrn_tid_o), 128'd0);
        chk("rst_data", rtrn_data_o, 128'd0);
        chk("rst_err", 128'(err_o), 128'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; req_i = 1'b0;
        idle(1);

        send(LD, 32'h40, 3'd0, 64'h0, 2'd1, 128'd0, ac);
        send(ST, 32'h48, 3'd3, 64'h1122334455667788, 2'd2, 128'd0, ac);
        send(IF, 32'h140, 3'd0, 64'h0, 2'd3, L1, ac);
        send(ST, 32'h43, 3'd0, 64'h00000000AB000000, 2'd0, 128'd0, ac);
        send(LD, 32'h40, 3'd0, 64'h0, 2'd1, L2, ac);
        idle(6);
        chk("err_clean", 128'(err_o), 128'd0);

        send(ST, 32'h42, 3'd2, 64'hFFFFFFFFFFFFFFFF, 2'd2, 128'd0, ac);
        req_i = 1'b0;
        @(negedge clk);
        chk("err_misaligned", 128'(err_o), 128'd1);
        @(posedge clk); #1;
        send(LD, 32'h40, 3'd0, 64'h0, 2'd3, L2, ac);
        idle(6);
        chk("err_sticky", 128'(err_o), 128'd1);

        s = cyc;
        for (int i = 0; i < 4; i++) begin
            send(LD, 32'h40, 3'd0, 64'h0, 2'(i), L2, a[i]);
        end
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ack_cycle", 128'(a[i] - s), 128'(exp_gap[i]));
        end
        idle(6);

        send(LD, 32'h80, 3'd0, 64'h0, 2'd0, 128'd0, a[0]);
        send(ST, 32'h88, 3'd3, 64'hDEADBEEFCAFEF00D, 2'd1, 128'd0, a[1]);
        chk("ld_st_consecutive", 128'(a[1] - a[0]), 128'd1);
        send(LD, 32'h80, 3'd0, 64'h0, 2'd2, {64'hDEADBEEFCAFEF00D, 64'h0}, ac);
        idle(6);

        send(ST, 32'h90, 3'd3, 64'h0123456789ABCDEF, 2'd0, 128'd0, a[0]);
        send(LD, 32'h90, 3'd0, 64'h0, 2'd1, {64'h0, 64'h0123456789ABCDEF}, a[1]);
        chk("st_ld_consecutive", 128'(a[1] - a[0]), 128'd1);
        idle(6);

        send(LD, 32'h40, 3'd0, 64'h0, 2'd0, L2, ac);
        send(LD, 32'h40, 3'd0, 64'h0, 2'd1, L2, ac);
        rst_i = 1'b1;
        req_i = 1'b1; req_type_i = LD; req_paddr_i = 32'h40; req_tid_i = 2'd2;
        sb.delete();
        @(negedge clk);
        chk("ack_during_midreset", 128'(req_ack_o), 128'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("ack_after_reset", 128'(req_ack_o), 128'd1);
        if (req_ack_o === 1'b1) push_exp(LD, 2'd2, 128'd0);
        chk("err_after_reset", 128'(err_o), 128'd0);
        @(posedge clk); #1;
        idle(6);

        send(RS, 32'h40, 3'd3, 64'hFFFFFFFFFFFFFFFF, 2'd3, 128'd0, ac);
        req_i = 1'b0;
        @(negedge clk);
        chk("err_reserved", 128'(err_o), 128'd1);
        @(posedge clk); #1;
        send(LD, 32'h40, 3'd0, 64'h0, 2'd0, 128'd0, ac);
        req_i = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wt_mem_responder.md
# wt_mem_responder

Memory-side responder for the write-through L1 cache request/return protocol: accepts cache requests (load, instruction fill, store) over the `req`/`ack` handshake and returns ordered responses on the `rtrn` channel after a fixed latency. It backs a flop-based line memory. It replaces the NoC adapter in cache-only testbenches and FPGA bring-up, sitting directly under the I$/D$ memory ports.

## Interface
- AddrWidth, 32, physical address width.
- DataWidth, 64, store data width (bytes = DataWidth/8, power of two).
- LineWidth, 128, cache line width returned on loads and fills (power of two, >= DataWidth).
- TidWidth, 2, transaction ID width.
- NumLines, 16, memory depth in lines (power of two).
- Latency, 3, accept-to-response cycles (>= 1).
- MaxTx, 2, maximum outstanding transactions (>= 1).

- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  request valid; held with all fields stable until acked.
- req_ack_o  out  1  request accepted this cycle.
- req_type_i  in  2  0 LOAD, 1 IFILL, 2 STORE, 3 reserved.
- req_paddr_i  in  AddrWidth  physical byte address.
- req_size_i  in  3  log2 of bytes stored; STORE only.
- req_data_i  in  DataWidth  store data, lane-positioned.
- req_tid_i  in  TidWidth  transaction ID.
- rtrn_vld_o  out  1  response valid, single cycle, no backpressure.
- rtrn_type_o  out  2  echoes request type.
- rtrn_tid_o  out  TidWidth  echoes request ID.
- rtrn_data_o  out  LineWidth  line data for LOAD/IFILL, zero otherwise.
- err_o  out  1  sticky protocol error.

## Operation
- Line offset bits: OB = log2(LineWidth/8). Index = paddr[OB +: log2(NumLines)]. Upper bits are ignored; addresses alias.
- LOAD/IFILL: line is read at acceptance and captured into the in-flight entry. Later stores do not affect an already-accepted load.
- STORE: written at the acceptance edge. For k in 0..2^size-1, line byte (o+k) ← req_data_i byte ((o mod DataWidth/8)+k), where o = paddr mod LineWidth/8.
- STORE error: size > log2(DataWidth/8) or o not aligned to 2^size sets err_o. Memory is unchanged, and the request is still acked and responded.
- Reserved type: err_o set, no memory effect, response with type 3, data 0.
- In-flight tracking: FIFO of MaxTx entries {type, tid, data, countdown}. Responses are strictly in acceptance order.
- err_o is cleared only by reset.
- Reset: memory cleared to zero; all in-flight entries discarded.

## Timing
- Accept in cycle k: req_i & req_ack_o high in cycle k. The response appears with rtrn_vld_o high in exactly cycle k+Latency.
- outstanding(c) = entries accepted before c whose response cycle is >= c.
- retiring(c) = rtrn_vld_o in cycle c.
- req_ack_o(c) = req_i & ~rst_i & (outstanding(c) - retiring(c) < MaxTx). It is combinational from req_i and registered state.
- Full throughput (one request per cycle) is reached iff MaxTx >= Latency. Otherwise acks stall until a retire.
- Simultaneous accept and retire in the same cycle is legal and keeps the count unchanged.
- Store-then-load to the same line in consecutive cycles returns the new data (write at edge k, read in cycle k+1).
- Outputs registered. Reset values: rtrn_vld_o 0, rtrn_type_o 0, rtrn_tid_o 0, rtrn_data_o 0, err_o 0. req_ack_o is 0 while rst_i is high.
- Reset mid-operation: no rtrn_vld_o in any cycle after rst_i is sampled; ack is available in the first cycle after rst_i deasserts.

## Test plan
- Post-reset LOAD paddr 0x40 tid 1 accepted cycle k -> rtrn_vld_o cycle k+3, type 0, tid 1, data 0.
- STORE size 3 paddr 0x48 data 0x1122334455667788 tid 2 -> ack response tid 2 data 0. Then IFILL 0x140 (aliases 0x40) -> data 0x1122334455667788_0000000000000000, type 1.
- STORE size 0 paddr 0x43 data 0x00000000AB000000, then LOAD 0x40 -> byte 3 = 0xAB, all other bytes unchanged. STORE size 2 paddr 0x42 -> err_o 1 and stays 1, memory unchanged, response still returned.
- Back-to-back LOADs, req_i held for tids 0,1,2,3 from cycle 0 -> acks in cycles 0,1,3,4; responses in cycles 3,4,6,7 with tids 0,1,2,3.
- LOAD 0x80 accepted cycle 0, STORE to 0x88 accepted cycle 1 -> load response data predates the store.
- Two loads outstanding, rst_i high one cycle -> no rtrn_vld_o afterwards, err_o 0, memory reads zero, a new request is acked in the first cycle after reset.
